// File: rtl/uio_bus_tx.sv
// ---------------------------------------------------------------------------
// uio_bus_tx
//
// Send side of a byte-parallel 4-phase req/ack link driven out of the
// bidirectional uio pins. Bytes are queued in a small FIFO. Each byte is then:
//   1. placed on bus_data with bus_oe = 8'hFF for one setup cycle,
//   2. announced by raising bus_req until the far end raises bus_ack,
//   3. held, with bus_req low, until bus_ack falls again.
// Any wait on bus_ack longer than TIMEOUT enabled cycles aborts the byte and
// sets the sticky err flag.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   ena       in   design enable; 0 freezes the FSM and blocks pushes
//   tx_data   in   [7:0] byte to queue
//   tx_valid  in   push request
//   tx_ready  out  FIFO not full
//   bus_data  out  [7:0] byte for uio_out
//   bus_oe    out  [7:0] uio_oe, 8'hFF while driving, else 8'h00
//   bus_req   out  request strobe to the far end
//   bus_ack   in   acknowledge from the far end (asynchronous)
//   err       out  sticky timeout flag
//   err_clr   in   clears err (a timeout in the same cycle wins)
//   level     out  [$clog2(DEPTH):0] FIFO occupancy
// ---------------------------------------------------------------------------
module uio_bus_tx #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [7:0]             tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic [7:0]             bus_data,
    output logic [7:0]             bus_oe,
    output logic                   bus_req,
    input  logic                   bus_ack,
    output logic                   err,
    input  logic                   err_clr,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [7:0]    LAST_WAIT  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_REQ,
        S_RELEASE
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          ack_meta_q, ack_sync_q;
    logic [7:0]    data_q, data_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          err_q;
    logic          push, pop, timeout;

    // tx_ready comes from the registered level, so a pop in the same cycle
    // never makes room for an extra push while full.
    assign tx_ready = (level_q != FULL_LEVEL);
    assign push     = tx_valid & tx_ready & ena;
    assign level    = level_q;
    assign bus_data = data_q;
    assign err      = err_q;

    // Two-flop synchronizer for the asynchronous acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
        end else begin
            ack_meta_q <= bus_ack;
            ack_sync_q <= ack_meta_q;
        end
    end

    // FIFO storage needs no reset: level and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    // FSM and handshake registers. A timeout sets err even if err_clr is
    // asserted in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q  <= 8'h00;
            cnt_q   <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            if (timeout) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    // Next state and outputs. Outputs decode the registered state only, so
    // an asynchronous reset drops oe and req immediately. IDLE refuses to
    // start while ack is still high, e.g. after a REQ timeout that the far
    // end answered late.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        timeout = 1'b0;
        bus_oe  = (state_q == S_IDLE) ? 8'h00 : 8'hFF;
        bus_req = (state_q == S_REQ);

        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    if (level_q != '0 && !ack_sync_q) begin
                        pop     = 1'b1;
                        data_d  = mem_q[rd_ptr_q];
                        state_d = S_SETUP;
                    end
                end
                S_SETUP: begin
                    cnt_d   = 8'h00;
                    state_d = S_REQ;
                end
                S_REQ: begin
                    if (ack_sync_q) begin
                        cnt_d   = 8'h00;
                        state_d = S_RELEASE;
                    end else if (cnt_q == LAST_WAIT) begin
                        timeout = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_RELEASE: begin
                    if (!ack_sync_q) begin
                        state_d = S_IDLE;
                    end else if (cnt_q == LAST_WAIT) begin
                        timeout = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uio_bus_tx.sv
// ---------------------------------------------------------------------------
// tb_uio_bus_tx
//
// Testbench for uio_bus_tx (DEPTH=4, TIMEOUT=10). A behavioural far end
// answers the req/ack handshake. A monitor records every byte offered on
// the bus and every pop, seen as bus_oe rising. Scenario tasks compare the
// DUT against expected byte order and an occupancy model: bytes accepted
// minus bytes popped.
// ---------------------------------------------------------------------------
module tb_uio_bus_tx;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 10;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] bus_data;
    logic [7:0] bus_oe;
    logic       bus_req;
    logic       bus_ack;
    logic       err;
    logic       err_clr;
    logic [2:0] level;

    int checks   = 0;
    int failures = 0;

    // Far-end behaviour: 0 = drive hold_ack, 1 = normal 4-phase with
    // resp_delay, 2 = raise ack on req and never lower it.
    int   resp_mode  = 0;
    int   resp_delay = 0;
    int   resp_cnt   = 0;
    logic hold_ack   = 1'b0;

    // Monitor and model state.
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int   pops      = 0;
    int   accepted  = 0;
    int   proto_err = 0;
    logic prev_req  = 1'b0;
    logic prev_oe   = 1'b0;
    logic [7:0] prev_data = 8'h00;

    uio_bus_tx #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .bus_data (bus_data),
        .bus_oe   (bus_oe),
        .bus_req  (bus_req),
        .bus_ack  (bus_ack),
        .err      (err),
        .err_clr  (err_clr),
        .level    (level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Far end: samples the bus 3 time units after each rising edge.
    initial begin
        bus_ack = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (resp_mode == 1) begin
                if (bus_req && !bus_ack) begin
                    resp_cnt++;
                    if (resp_cnt >= resp_delay) bus_ack = 1'b1;
                end else if (!bus_req) begin
                    resp_cnt = 0;
                    bus_ack  = 1'b0;
                end
            end else if (resp_mode == 2) begin
                if (bus_req) bus_ack = 1'b1;
            end else begin
                bus_ack = hold_ack;
            end
        end
    end

    // Monitor: records bytes at req rising, counts pops at oe rising, and
    // flags a req without a preceding setup cycle or data changing while
    // driven.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus_req && !prev_req) begin
                got.push_back(bus_data);
                if (!prev_oe) proto_err++;
            end
            if (bus_oe == 8'hFF && !prev_oe) pops++;
            if (bus_oe == 8'hFF && prev_oe && bus_data !== prev_data) proto_err++;
            prev_req  = bus_req;
            prev_oe   = (bus_oe == 8'hFF);
            prev_data = bus_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Move to 2 time units after the next rising edge, where the bench
    // samples outputs and drives inputs.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        ena      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        err_clr  = 1'b0;
        resp_mode = 0;
        hold_ack  = 1'b0;
        rst_n    = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        got.delete();
        exp_q.delete();
        pops      = 0;
        accepted  = 0;
        proto_err = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", tx_ready); end
        checks++; if (bus_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus_data); end
        checks++; if (bus_oe !== 8'h00) begin failures++; $display("FAIL reset_oe got=%h exp=00", bus_oe); end
        checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus_req); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    endtask

    task automatic test_single_byte();
        int n;
        apply_reset();
        resp_mode  = 1;
        resp_delay = 3;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        checks++; if (level !== 3'd1) begin failures++; $display("FAIL single_level_after_push got=%0d exp=1", level); end
        checks++; if (bus_oe !== 8'h00) begin failures++; $display("FAIL single_oe_after_push got=%h exp=00", bus_oe); end
        tick();
        checks++; if (bus_oe !== 8'hFF) begin failures++; $display("FAIL single_setup_oe got=%h exp=FF", bus_oe); end
        checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL single_setup_req got=%b exp=0", bus_req); end
        checks++; if (bus_data !== 8'hA5) begin failures++; $display("FAIL single_setup_data got=%h exp=A5", bus_data); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL single_level_after_pop got=%0d exp=0", level); end
        tick();
        checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL single_req_rise got=%b exp=1", bus_req); end
        n = 0;
        while (bus_oe !== 8'h00 && n < 100) begin tick(); n++; end
        checks++; if (n >= 100) begin failures++; $display("FAIL single_done_wait got=timeout exp=oe_low"); end
        checks++; if (got.size() != 1 || got[0] !== 8'hA5) begin failures++; $display("FAIL single_byte got_count=%0d exp=1 byte A5", got.size()); end
        checks++; if (bus_data !== 8'hA5) begin failures++; $display("FAIL single_data_idle got=%h exp=A5", bus_data); end
        checks++; if (level !== 3'd0 || err !== 1'b0) begin failures++; $display("FAIL single_end_state got=level%0d err%b exp=level0 err0", level, err); end
        checks++; if (proto_err != 0) begin failures++; $display("FAIL single_protocol got=%0d exp=0", proto_err); end
    endtask

    task automatic test_fifo_full();
        int n;
        apply_reset();
        resp_mode = 0;
        hold_ack  = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tx_data  = 8'(i);
            tx_valid = 1'b1;
            tick();
        end
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", tx_ready); end
        checks++; if (level !== 3'd4) begin failures++; $display("FAIL full_level got=%0d exp=4", level); end
        tx_data = 8'h06;
        tick();
        tx_valid = 1'b0;
        checks++; if (level !== 3'd4) begin failures++; $display("FAIL full_push_blocked got=%0d exp=4", level); end
        resp_mode  = 1;
        resp_delay = 1;
        n = 0;
        while (tx_ready !== 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (n >= 100) begin failures++; $display("FAIL full_ready_return got=timeout exp=ready"); end
        tx_data  = 8'h06;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        n = 0;
        while ((got.size() < 6 || bus_oe !== 8'h00) && n < 300) begin tick(); n++; end
        checks++; if (got.size() != 6) begin failures++; $display("FAIL full_count got=%0d exp=6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            checks++; if (got[i] !== 8'(i + 1)) begin failures++; $display("FAIL full_order[%0d] got=%h exp=%h", i, got[i], 8'(i + 1)); end
        end
        checks++; if (err !== 1'b0 || proto_err != 0) begin failures++; $display("FAIL full_clean got=err%b proto%0d exp=err0 proto0", err, proto_err); end
    endtask

    task automatic test_timeout();
        int n;
        apply_reset();
        resp_mode = 0;
        hold_ack  = 1'b0;
        tx_data = 8'h3C; tx_valid = 1'b1; tick();
        tx_data = 8'h4D; tick();
        tx_valid = 1'b0;
        n = 0;
        while (bus_req !== 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (n >= 20) begin failures++; $display("FAIL to_req_wait got=timeout exp=req"); end
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            if (k == TIMEOUT - 1) begin
                checks++; if (bus_req !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL to_early got=req%b err%b exp=req1 err0", bus_req, err); end
            end
        end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", err); end
        checks++; if (bus_req !== 1'b0 || bus_oe !== 8'h00) begin failures++; $display("FAIL to_drop got=req%b oe%h exp=req0 oe00", bus_req, bus_oe); end
        tick();
        checks++; if (bus_oe !== 8'hFF || bus_data !== 8'h4D) begin failures++; $display("FAIL to_next_byte got=oe%h data%h exp=oeFF data4D", bus_oe, bus_data); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL to_level got=%0d exp=0", level); end
        err_clr = 1'b1;
        tick();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL to_err_clr got=%b exp=0", err); end
        n = 0;
        while (bus_oe !== 8'h00 && n < 30) begin tick(); n++; end
        checks++; if (n >= 30) begin failures++; $display("FAIL to_second_wait got=timeout exp=abort"); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_set_wins got=%b exp=1", err); end
        tick();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL to_clr_after got=%b exp=0", err); end
        err_clr = 1'b0;
    endtask

    task automatic test_stuck_ack();
        int n;
        int oe_seen;
        apply_reset();
        resp_mode = 2;
        tx_data = 8'h77; tx_valid = 1'b1; tick();
        tx_data = 8'h88; tick();
        tx_valid = 1'b0;
        n = 0;
        while (err !== 1'b1 && n < 60) begin tick(); n++; end
        checks++; if (n >= 60) begin failures++; $display("FAIL stuck_err_wait got=timeout exp=err"); end
        checks++; if (bus_oe !== 8'h00 || bus_req !== 1'b0) begin failures++; $display("FAIL stuck_drop got=oe%h req%b exp=oe00 req0", bus_oe, bus_req); end
        oe_seen = 0;
        repeat (6) begin
            tick();
            if (bus_oe !== 8'h00) oe_seen++;
        end
        checks++; if (oe_seen != 0) begin failures++; $display("FAIL stuck_no_setup got=%0d exp=0", oe_seen); end
        checks++; if (level !== 3'd1) begin failures++; $display("FAIL stuck_level got=%0d exp=1", level); end
        resp_mode = 0;
        hold_ack  = 1'b0;
        n = 0;
        while (bus_oe !== 8'hFF && n < 20) begin tick(); n++; end
        checks++; if (n >= 20 || bus_data !== 8'h88) begin failures++; $display("FAIL stuck_resume got=data%h exp=data88", bus_data); end
        resp_mode  = 1;
        resp_delay = 0;
        n = 0;
        while (bus_oe !== 8'h00 && n < 50) begin tick(); n++; end
        checks++; if (n >= 50) begin failures++; $display("FAIL stuck_drain got=timeout exp=idle"); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_async_reset();
        int n;
        apply_reset();
        resp_mode = 0;
        hold_ack  = 1'b0;
        tx_data = 8'h11; tx_valid = 1'b1; tick();
        tx_data = 8'h22; tick();
        tx_valid = 1'b0;
        n = 0;
        while (bus_req !== 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (n >= 20) begin failures++; $display("FAIL areset_req_wait got=timeout exp=req"); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (bus_req !== 1'b0 || bus_oe !== 8'h00) begin failures++; $display("FAIL areset_drop got=req%b oe%h exp=req0 oe00", bus_req, bus_oe); end
        checks++; if (level !== 3'd0 || tx_ready !== 1'b1) begin failures++; $display("FAIL areset_fifo got=level%0d ready%b exp=level0 ready1", level, tx_ready); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_push_pop_same();
        int n;
        apply_reset();
        resp_mode = 0;
        hold_ack  = 1'b1;
        repeat (4) tick();
        tx_data = 8'h31; tx_valid = 1'b1; tick();
        tx_data = 8'h32; tick();
        tx_valid = 1'b0;
        checks++; if (level !== 3'd2 || bus_oe !== 8'h00) begin failures++; $display("FAIL pp_hold got=level%0d oe%h exp=level2 oe00", level, bus_oe); end
        hold_ack = 1'b0;
        tick();
        tick();
        checks++; if (level !== 3'd2 || bus_oe !== 8'h00) begin failures++; $display("FAIL pp_pre got=level%0d oe%h exp=level2 oe00", level, bus_oe); end
        tx_data  = 8'h33;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        checks++; if (level !== 3'd2) begin failures++; $display("FAIL pp_level got=%0d exp=2", level); end
        checks++; if (bus_oe !== 8'hFF || bus_data !== 8'h31) begin failures++; $display("FAIL pp_pop got=oe%h data%h exp=oeFF data31", bus_oe, bus_data); end
        resp_mode  = 1;
        resp_delay = 2;
        n = 0;
        while ((got.size() < 3 || bus_oe !== 8'h00) && n < 200) begin tick(); n++; end
        checks++; if (got.size() != 3) begin failures++; $display("FAIL pp_count got=%0d exp=3", got.size()); end
        else begin
            checks++; if (got[0] !== 8'h31 || got[1] !== 8'h32 || got[2] !== 8'h33) begin failures++; $display("FAIL pp_order got=%h %h %h exp=31 32 33", got[0], got[1], got[2]); end
        end
    endtask

    task automatic test_random();
        int n;
        int model_level;
        int bad;
        logic ena_now;
        logic [7:0] oe_before;
        logic [7:0] data_before;
        logic req_before;
        apply_reset();
        resp_mode = 1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            model_level = accepted - pops;
            checks++; if (int'(level) != model_level) begin failures++; $display("FAIL rand_level[%0d] got=%0d exp=%0d", cyc, level, model_level); end
            checks++; if (tx_ready !== (model_level != DEPTH)) begin failures++; $display("FAIL rand_ready[%0d] got=%b exp=%b", cyc, tx_ready, model_level != DEPTH); end
            ena        = ($urandom_range(0, 9) != 0);
            tx_valid   = $urandom_range(0, 1) == 1;
            tx_data    = 8'($urandom);
            resp_delay = $urandom_range(0, 4);
            if (tx_valid && ena && model_level != DEPTH) begin
                accepted++;
                exp_q.push_back(tx_data);
            end
            ena_now     = ena;
            oe_before   = bus_oe;
            data_before = bus_data;
            req_before  = bus_req;
            tick();
            if (!ena_now) begin
                checks++; if (bus_oe !== oe_before || bus_req !== req_before || bus_data !== data_before) begin failures++; $display("FAIL rand_hold[%0d] got=oe%h req%b data%h exp=oe%h req%b data%h", cyc, bus_oe, bus_req, bus_data, oe_before, req_before, data_before); end
            end
        end
        tx_valid = 1'b0;
        ena      = 1'b1;
        n = 0;
        while ((got.size() < exp_q.size() || bus_oe !== 8'h00) && n < 1000) begin tick(); n++; end
        checks++; if (got.size() != exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got.size(), exp_q.size()); end
        bad = 0;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            if (got[i] !== exp_q[i]) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL rand_order got=%0d wrong bytes exp=0", bad); end
        checks++; if (err !== 1'b0 || proto_err != 0) begin failures++; $display("FAIL rand_clean got=err%b proto%0d exp=err0 proto0", err, proto_err); end
    endtask

    initial begin
        ena      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        err_clr  = 1'b0;
        rst_n    = 1'b1;
        #1;
        test_reset();
        test_single_byte();
        test_fifo_full();
        test_timeout();
        test_stuck_ack();
        test_async_reset();
        test_push_pop_same();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
